// File: rtl/sigma_frame_capture.sv
// sigma_frame_capture: frames per-sample deltas of a sigma(a*b+c) running sum into held 12-bit results; SFC_PEAK_EN adds per-frame peak tracking
module sigma_frame_capture #(
  parameter int PIPE_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_sum,
  input  logic        i_in_valid,
  input  logic [3:0]  i_frame_len,
  input  logic        i_clear,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [11:0] o_result,
  output logic        o_overrun,
  output logic [7:0]  o_peak
);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state_q, state_d;
  logic [PIPE_LAT-1:0] dv_sr_q, dv_sr_d;
  logic [7:0] prev_sum_q, prev_sum_d, delta;
  logic [4:0] len_q, len_d, count_q, count_d, cnt_inc, len_eff;
  logic [11:0] total_q, total_d, frame_sum, result_q, result_d;
  logic valid_q, valid_d, overrun_q, overrun_d;
  logic dv, complete, load;
  assign dv = dv_sr_q[PIPE_LAT-1];
  assign delta = i_sum - prev_sum_q;
  assign load = complete & (~valid_q | i_ready);
  // valid delay line tracks the accumulator latency; prev_sum follows i_sum every cycle
  always_comb begin
    dv_sr_d = (dv_sr_q << 1) | PIPE_LAT'(i_in_valid);
    prev_sum_d = i_sum;
  end
  // frame sequencing: a frame starts from IDLE on the first dv and ends when count reaches len
  always_comb begin
    cnt_inc = (state_q == IDLE) ? 5'd1 : count_q + 5'd1;
    len_eff = (state_q == IDLE) ? ((i_frame_len == 4'd0) ? 5'd16 : {1'b0, i_frame_len}) : len_q;
    frame_sum = ((state_q == IDLE) ? 12'd0 : total_q) + {4'd0, delta};
    complete = dv & ~i_clear & (cnt_inc == len_eff);
    state_d = state_q;
    len_d = len_q;
    count_d = count_q;
    total_d = total_q;
    if (i_clear) begin
      state_d = IDLE;
      count_d = 5'd0;
      total_d = 12'd0;
    end else if (dv) begin
      len_d = len_eff;
      state_d = complete ? IDLE : COLLECT;
      count_d = complete ? 5'd0 : cnt_inc;
      total_d = complete ? 12'd0 : frame_sum;
    end
  end
  // result hold: a completion either replaces an accepted/empty slot or is dropped as an overrun
  always_comb begin
    valid_d = load | (valid_q & ~i_ready);
    result_d = load ? frame_sum : result_q;
    overrun_d = ~i_clear & (overrun_q | (complete & ~load));
  end
  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_sr_q <= '0;
      prev_sum_q <= 8'd0;
      state_q <= IDLE;
      len_q <= 5'd0;
      count_q <= 5'd0;
      total_q <= 12'd0;
      valid_q <= 1'b0;
      result_q <= 12'd0;
      overrun_q <= 1'b0;
    end else begin
      dv_sr_q <= dv_sr_d;
      prev_sum_q <= prev_sum_d;
      state_q <= state_d;
      len_q <= len_d;
      count_q <= count_d;
      total_q <= total_d;
      valid_q <= valid_d;
      result_q <= result_d;
      overrun_q <= overrun_d;
    end
  end
  assign o_valid = valid_q;
  assign o_result = result_q;
  assign o_overrun = overrun_q;
`ifdef SFC_PEAK_EN
  logic [7:0] peak_q, peak_d, peak_run, peak_new, peak_out_q, peak_out_d;
  // running maximum of delta within the frame, published alongside the result
  always_comb begin
    peak_run = (state_q == IDLE) ? 8'd0 : peak_q;
    peak_new = (delta > peak_run) ? delta : peak_run;
    peak_d = (i_clear | complete) ? 8'd0 : (dv ? peak_new : peak_q);
    peak_out_d = load ? peak_new : peak_out_q;
  end
  // peak registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q <= 8'd0;
      peak_out_q <= 8'd0;
    end else begin
      peak_q <= peak_d;
      peak_out_q <= peak_out_d;
    end
  end
  assign o_peak = peak_out_q;
`else
  assign o_peak = 8'h00;
`endif
endmodule

// File: tb/tb_sigma_frame_capture.sv
// tb_sigma_frame_capture: table vectors, directed corner sequences and random traffic against a sample-level frame model
module tb_sigma_frame_capture;
  localparam int P = 4;
`ifdef SFC_PEAK_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif
  logic clk, rst, i_in_valid, i_clear, i_ready, o_valid, o_overrun;
  logic [7:0] i_sum, o_peak;
  logic [3:0] i_frame_len;
  logic [11:0] o_result;
  sigma_frame_capture #(.PIPE_LAT(P)) dut (
    .clk(clk), .rst(rst), .i_sum(i_sum), .i_in_valid(i_in_valid),
    .i_frame_len(i_frame_len), .i_clear(i_clear), .i_ready(i_ready),
    .o_valid(o_valid), .o_result(o_result), .o_overrun(o_overrun), .o_peak(o_peak)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int nvec = 0, nmis = 0;
  logic [7:0] acc;
  int tq[0:P];
  bit vq[0:P];
  bit m_busy, m_valid, m_ov;
  int m_len, m_cnt, m_tot, m_pk, m_res, m_opk;
  typedef struct {
    int flen; int n; int a0; int b0; int c0; int a; int b; int c; int gap; int res; int pk;
  } vec_t;
  vec_t tbl[6];

  task automatic expect_eq(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model();
    nvec++;
    if (o_valid !== m_valid || int'(o_result) != m_res || o_overrun !== m_ov || int'(o_peak) != m_opk) begin
      nmis++;
      $display("FAIL model @%0t: valid %b/%b result %0d/%0d overrun %b/%b peak %0d/%0d (got/expected)",
               $time, o_valid, m_valid, o_result, m_res, o_overrun, m_ov, o_peak, m_opk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_in_valid = 1'b0;
    #1;
    expect_eq("rst_valid", int'(o_valid), 0);
    expect_eq("rst_result", int'(o_result), 0);
    expect_eq("rst_overrun", int'(o_overrun), 0);
    expect_eq("rst_peak", int'(o_peak), 0);
    acc = 8'd0;
    for (int k = 0; k <= P; k++) begin tq[k] = 0; vq[k] = 1'b0; end
    i_sum = 8'd0;
    m_busy = 0; m_valid = 0; m_ov = 0; m_res = 0; m_opk = 0; m_cnt = 0; m_tot = 0; m_pk = 0; m_len = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // one clock: present operands (the accumulator term a*b+c), advance the frame model, compare after the edge
  task automatic cycle(input int a, input int b, input int c, input bit v);
    bit done;
    int d;
    tq[0] = a * b + c;
    vq[0] = v;
    i_in_valid = v;
    d = tq[P];
    done = 1'b0;
    if (i_clear) begin
      m_busy = 1'b0;
    end else if (vq[P]) begin
      if (!m_busy) begin
        m_busy = 1'b1;
        m_len = (i_frame_len == 4'd0) ? 16 : int'(i_frame_len);
        m_cnt = 0; m_tot = 0; m_pk = 0;
      end
      m_cnt++;
      m_tot += d;
      if (d > m_pk) m_pk = d;
      if (m_cnt == m_len) begin done = 1'b1; m_busy = 1'b0; end
    end
    if (done && m_valid && !i_ready) m_ov = 1'b1;
    else if (done) begin m_valid = 1'b1; m_res = m_tot; m_opk = PK ? m_pk : 0; end
    else if (i_ready) m_valid = 1'b0;
    if (i_clear) m_ov = 1'b0;
    @(posedge clk);
    #1;
    acc = acc + 8'(tq[P-1]);
    for (int k = P; k > 0; k--) begin tq[k] = tq[k-1]; vq[k] = vq[k-1]; end
    tq[0] = 0;
    vq[0] = 1'b0;
    i_sum = acc;
    check_model();
  endtask

  task automatic wait_valid(output int k);
    k = 1;
    while (!o_valid && k < 40) begin cycle(0, 0, 0, 0); k++; end
  endtask

  task automatic drain();
    i_ready = 1'b1;
    cycle(0, 0, 0, 0);
    i_ready = 1'b0;
  endtask

  initial begin
    int k;
    tbl[0] = '{flen: 2,  n: 2,  a0: 3,  b0: 4,  c0: 1,  a: 15, b: 15, c: 15, gap: 0, res: 253,  pk: 240};
    tbl[1] = '{flen: 4,  n: 4,  a0: 15, b0: 15, c0: 15, a: 15, b: 15, c: 15, gap: 0, res: 960,  pk: 240};
    tbl[2] = '{flen: 0,  n: 16, a0: 1,  b0: 1,  c0: 0,  a: 1,  b: 1,  c: 0,  gap: 1, res: 16,   pk: 1};
    tbl[3] = '{flen: 1,  n: 1,  a0: 2,  b0: 3,  c0: 0,  a: 2,  b: 3,  c: 0,  gap: 0, res: 6,    pk: 6};
    tbl[4] = '{flen: 3,  n: 3,  a0: 1,  b0: 2,  c0: 0,  a: 1,  b: 2,  c: 0,  gap: 2, res: 6,    pk: 2};
    tbl[5] = '{flen: 15, n: 15, a0: 15, b0: 15, c0: 15, a: 15, b: 15, c: 15, gap: 0, res: 3600, pk: 240};
    i_clear = 1'b0; i_ready = 1'b0; i_frame_len = 4'd0; i_in_valid = 1'b0; i_sum = 8'd0; rst = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      i_frame_len = 4'(tbl[i].flen);
      for (int s = 0; s < tbl[i].n; s++) begin
        if (s > 0) for (int g = 0; g < tbl[i].gap; g++) cycle(2, 2, 2, 0);
        if (s == 0) cycle(tbl[i].a0, tbl[i].b0, tbl[i].c0, 1);
        else cycle(tbl[i].a, tbl[i].b, tbl[i].c, 1);
      end
      wait_valid(k);
      expect_eq($sformatf("vec%0d_latency", i), k, P + 1);
      expect_eq($sformatf("vec%0d_result", i), int'(o_result), tbl[i].res);
      expect_eq($sformatf("vec%0d_peak", i), int'(o_peak), PK ? tbl[i].pk : 0);
      drain();
      expect_eq($sformatf("vec%0d_accepted", i), int'(o_valid), 0);
    end
    // held result with a second completion dropped as overrun
    i_frame_len = 4'd1;
    cycle(2, 3, 0, 1);
    wait_valid(k);
    expect_eq("ovr_first", int'(o_result), 6);
    cycle(1, 1, 1, 1);
    for (int j = 0; j < P + 1; j++) cycle(0, 0, 0, 0);
    expect_eq("ovr_held_result", int'(o_result), 6);
    expect_eq("ovr_held_valid", int'(o_valid), 1);
    expect_eq("ovr_flag", int'(o_overrun), 1);
    drain();
    expect_eq("ovr_accepted", int'(o_valid), 0);
    expect_eq("ovr_sticky", int'(o_overrun), 1);
    i_clear = 1'b1;
    cycle(0, 0, 0, 0);
    i_clear = 1'b0;
    expect_eq("ovr_cleared", int'(o_overrun), 0);
    // completion in the same cycle the held result is accepted
    cycle(2, 2, 0, 1);
    wait_valid(k);
    expect_eq("same_first", int'(o_result), 4);
    cycle(3, 3, 0, 1);
    for (int j = 0; j < P - 1; j++) cycle(0, 0, 0, 0);
    i_ready = 1'b1;
    cycle(0, 0, 0, 0);
    i_ready = 1'b0;
    expect_eq("same_valid", int'(o_valid), 1);
    expect_eq("same_result", int'(o_result), 9);
    expect_eq("same_overrun", int'(o_overrun), 0);
    drain();
    // reset in the middle of a frame
    i_frame_len = 4'd3;
    cycle(1, 2, 0, 1);
    cycle(1, 2, 0, 1);
    cycle(0, 0, 0, 0);
    do_reset();
    for (int j = 0; j < 3; j++) cycle(1, 2, 0, 1);
    wait_valid(k);
    expect_eq("rst_mid_latency", k, P + 1);
    expect_eq("rst_mid_result", int'(o_result), 6);
    drain();
    // clear coincident with a valid sample discards it and the partial frame
    i_frame_len = 4'd2;
    cycle(1, 1, 5, 1);
    cycle(9, 9, 9, 1);
    for (int j = 0; j < P - 1; j++) cycle(0, 0, 0, 0);
    i_clear = 1'b1;
    cycle(0, 0, 0, 0);
    i_clear = 1'b0;
    cycle(2, 2, 0, 1);
    cycle(3, 1, 0, 1);
    wait_valid(k);
    expect_eq("clear_result", int'(o_result), 7);
    drain();
    // frame length change mid-frame is ignored until the next frame
    i_frame_len = 4'd2;
    cycle(4, 4, 0, 1);
    for (int j = 0; j < P; j++) cycle(0, 0, 0, 0);
    i_frame_len = 4'd5;
    cycle(5, 5, 0, 1);
    wait_valid(k);
    expect_eq("len_change_result", int'(o_result), 41);
    drain();
    // random traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      i_ready = ($urandom_range(0, 2) != 0);
      i_clear = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 19) == 0) i_frame_len = 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1) == 1);
    end
    i_clear = 1'b0;
    i_ready = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
